// File: rtl/l1_tb_pkg.sv
// Shared types, defaults and helpers for the cache response checker.
package l1_tb_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } chk_state_e;

  localparam int CHK_IDX_W   = 8;
  localparam int CHK_TIMEOUT = 64;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

  // Expand a 4-bit byte mask into a 32-bit bit mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int b = 0; b < 4; b++) begin
      m[8*b +: 8] = {8{s[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/chk_shadow_mem.sv
// Shadow copy of what the cache should hold: per-index tag, byte-valid mask
// and data word. Writes merge on a tag hit and replace the entry on a miss.
// Reads are combinational, so a read in the same cycle as a write to the
// same index sees the pre-write contents.
module chk_shadow_mem
  import l1_tb_pkg::*;
#(
  parameter int IDX_W = CHK_IDX_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en_i,
  input  logic [29:0] wr_waddr_i,
  input  logic [31:0] wr_data_i,
  input  logic [3:0]  wr_strb_i,
  input  logic [29:0] rd_waddr_i,
  output logic        rd_hit_o,
  output logic [3:0]  rd_mask_o,
  output logic [31:0] rd_data_o
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int TAG_W = 30 - IDX_W;

  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [3:0]       mask_q [DEPTH];
  logic [31:0]      data_q [DEPTH];

  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  logic             wr_hit;

  assign wr_idx = wr_waddr_i[IDX_W-1:0];
  assign wr_tag = wr_waddr_i[29:IDX_W];
  assign rd_idx = rd_waddr_i[IDX_W-1:0];
  assign rd_tag = rd_waddr_i[29:IDX_W];
  assign wr_hit = (tag_q[wr_idx] == wr_tag);

  // Tag and mask: cleared on reset, merged on hit, replaced on miss.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        mask_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      if (wr_hit) begin
        mask_q[wr_idx] <= mask_q[wr_idx] | wr_strb_i;
      end else begin
        tag_q[wr_idx]  <= wr_tag;
        mask_q[wr_idx] <= wr_strb_i;
      end
    end
  end

  // Data bytes: strobed bytes written; on a tag miss the others are zeroed.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_i[b]) begin
          data_q[wr_idx][8*b +: 8] <= wr_data_i[8*b +: 8];
        end else if (!wr_hit) begin
          data_q[wr_idx][8*b +: 8] <= 8'h00;
        end
      end
    end
  end

  // Only a tag match with at least one valid byte is worth comparing.
  always_comb begin
    rd_mask_o = mask_q[rd_idx];
    rd_data_o = data_q[rd_idx];
    rd_hit_o  = (tag_q[rd_idx] == rd_tag) && (mask_q[rd_idx] != 4'h0);
  end

endmodule

// File: rtl/resp_checker.sv
// Passive checker for a single-outstanding cache port. Tracks writes in a
// shadow store and compares read responses against it on valid bytes.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | no request outstanding; a response here is a protocol error
//   S_WAIT | request latched, waiting for resp_valid or the timeout
module resp_checker
  import l1_tb_pkg::*;
#(
  parameter int IDX_W   = CHK_IDX_W,
  parameter int TIMEOUT = CHK_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  input  logic        resp_stall,
  input  logic        resp_valid,
  input  logic [31:0] resp_rdata,
  output logic [15:0] chk_count,
  output logic [15:0] err_count,
  output logic [15:0] wr_count,
  output logic [15:0] unchk_count,
  output logic        proto_err,
  output logic        timeout_err,
  output logic [31:0] first_err_addr,
  output logic [31:0] first_err_exp,
  output logic [31:0] first_err_got,
  output logic        busy
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  chk_state_e       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic [31:0] addr_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        wr_pend_q;

  logic [15:0] chk_q, err_q, wr_q, unchk_q;
  logic        proto_q, tmo_q;
  logic [31:0] fe_addr_q, fe_exp_q, fe_got_q;

  logic accept, take, proto_set, tmo_set, resp_rd;

  logic        sh_hit;
  logic [3:0]  sh_mask;
  logic [31:0] sh_data;
  logic [31:0] byte_mask;
  logic [31:0] exp_masked;
  logic        mism;

  assign accept = req_valid && !resp_stall;

  // The write lands in the shadow the cycle after accept, from the latched
  // request; the earliest read that could observe it responds later still.
  chk_shadow_mem #(.IDX_W(IDX_W)) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_pend_q),
    .wr_waddr_i(addr_q[31:2]),
    .wr_data_i (wdata_q),
    .wr_strb_i (wstrb_q),
    .rd_waddr_i(addr_q[31:2]),
    .rd_hit_o  (sh_hit),
    .rd_mask_o (sh_mask),
    .rd_data_o (sh_data)
  );

  assign byte_mask  = strb_to_mask(sh_mask);
  assign exp_masked = sh_data & byte_mask;
  assign mism       = ((resp_rdata & byte_mask) != exp_masked);

  // Next-state, timeout down-counter and event strobes.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    take      = 1'b0;
    proto_set = 1'b0;
    tmo_set   = 1'b0;
    resp_rd   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (resp_valid) proto_set = 1'b1;
        if (accept) begin
          take    = 1'b1;
          state_d = S_WAIT;
          timer_d = TMR_LOAD;
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          resp_rd = !we_q;
          if (accept) begin
            take    = 1'b1;
            timer_d = TMR_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          // A second request while one is outstanding is flagged and dropped.
          if (accept) proto_set = 1'b1;
          if (timer_q == '0) begin
            tmo_set = 1'b1;
            state_d = S_IDLE;
          end else begin
            timer_d = timer_q - TMR_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
    end
  end

  // Latch the accepted request and schedule its shadow write.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      wr_pend_q <= take && req_we;
      if (take) begin
        addr_q  <= req_addr;
        we_q    <= req_we;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
    end
  end

  // Saturating counters and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_q   <= '0;
      err_q   <= '0;
      wr_q    <= '0;
      unchk_q <= '0;
      proto_q <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      if (take && req_we) wr_q <= sat_inc(wr_q);
      if (resp_rd) begin
        if (sh_hit) begin
          chk_q <= sat_inc(chk_q);
          if (mism) err_q <= sat_inc(err_q);
        end else begin
          unchk_q <= sat_inc(unchk_q);
        end
      end
      if (proto_set) proto_q <= 1'b1;
      if (tmo_set)   tmo_q   <= 1'b1;
    end
  end

  // First mismatch since reset; err_q never returns to zero once counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      fe_addr_q <= '0;
      fe_exp_q  <= '0;
      fe_got_q  <= '0;
    end else if (resp_rd && sh_hit && mism && (err_q == 16'h0000)) begin
      fe_addr_q <= addr_q;
      fe_exp_q  <= exp_masked;
      fe_got_q  <= resp_rdata;
    end
  end

  assign chk_count      = chk_q;
  assign err_count      = err_q;
  assign wr_count       = wr_q;
  assign unchk_count    = unchk_q;
  assign proto_err      = proto_q;
  assign timeout_err    = tmo_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_exp  = fe_exp_q;
  assign first_err_got  = fe_got_q;
  assign busy           = (state_q == S_WAIT);

endmodule

// File: doc/resp_checker.md
RESP_CHECKER -- requirements
Module: resp_checker

Interface
REQ-001 SHALL have parameter IDX_W, default 8, shadow word-index width (2^IDX_W entries).
REQ-002 SHALL have parameter TIMEOUT, default 64, maximum cycles from request accept to response.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports req_valid/req_we  input  1 each  the monitored request handshake and direction.
REQ-006 SHALL have ports req_addr/req_wdata  input  32 each  the monitored request address and write data.
REQ-007 SHALL have port req_wstrb  input  4  the monitored byte-write strobe.
REQ-008 SHALL have port resp_stall  input  1  the cache stall; a request is accepted when req_valid && !resp_stall.
REQ-009 SHALL have ports resp_valid  input  1  and resp_rdata  input  32  the cache response.
REQ-010 SHALL have ports chk_count/err_count/wr_count/unchk_count  output  16 each  checked reads, mismatches, accepted writes, unchecked reads.
REQ-011 SHALL have ports proto_err/timeout_err  output  1 each  sticky protocol-violation and timeout flags.
REQ-012 SHALL have ports first_err_addr/first_err_exp/first_err_got  output  32 each  capture of the first data mismatch.
REQ-013 SHALL have port busy  output  1  high while a request is outstanding.

Function
REQ-014 SHALL implement FSM S_IDLE/S_WAIT; S_IDLE->S_WAIT on accept; S_WAIT->S_IDLE on resp_valid or timeout.
REQ-015 SHALL, on accept, latch addr, we, wdata and wstrb; busy SHALL rise the cycle after accept.
REQ-016 SHALL keep per-entry shadow fields tag=addr[31:IDX_W+2], 4-bit byte-valid mask and 32-bit data, indexed by addr[IDX_W+1:2].
REQ-017 SHALL, on an accepted write with a matching tag, merge the strobed bytes into data and OR wstrb into the mask.
REQ-018 SHALL, on an accepted write with a tag mismatch, replace the tag and set the mask to wstrb, with data holding only the strobed bytes.
REQ-019 SHALL, on a read response, compare resp_rdata against the shadow data on mask-valid bytes only; a tag miss or all-zero mask SHALL increment unchk_count.
REQ-020 SHALL, on a compared read, increment chk_count and, on a mismatch, also increment err_count.
REQ-021 SHALL capture first_err_* only on the first mismatch after reset; first_err_exp SHALL hold masked-expected bytes with invalid bytes zero.
REQ-022 SHALL treat a write response (resp_valid while the latched we=1) as completion only, with no data comparison.
REQ-023 SHALL saturate all counters at 16'hFFFF.
REQ-024 SHALL set proto_err on resp_valid in S_IDLE, or on an accept in S_WAIT without a same-cycle resp_valid.
REQ-025 SHALL, on resp_valid and a new accept in the same S_WAIT cycle, complete the old request and enter S_WAIT with the new one (back-to-back).
REQ-026 SHALL, on a shadow write and a read response to the same index in the same cycle, compare against pre-write shadow contents.
REQ-027 SHALL count S_WAIT cycles; on reaching TIMEOUT it SHALL set timeout_err and return to S_IDLE, and a later resp_valid SHALL raise proto_err.
REQ-028 SHALL leave proto_err and timeout_err set until reset.

Reset
REQ-029 SHALL, with rst high at a clock edge, enter S_IDLE, clear all counters, flags, first_err_* and busy, and clear every shadow mask and tag.
REQ-030 SHALL discard an outstanding request when rst asserts mid-transaction; shadow data bits need no reset.

Structure
REQ-031 SHALL take chk_state_e, CHK_IDX_W and CHK_TIMEOUT defaults from shared package l1_tb_pkg.
REQ-032 SHALL place the tag/mask/data array and byte-merge logic in sub-module chk_shadow_mem.

Verification
REQ-033 SHALL verify: write 0x0000_1000 data 0xA5A5_0001 strb F, then read returning 0xA5A5_0001 -> chk_count=1, err_count=0.
REQ-034 SHALL verify: after REQ-033, read 0x0000_1000 returning 0xA5A5_0000 -> err_count=1, first_err_addr=0x0000_1000, exp=0xA5A5_0001, got=0xA5A5_0000.
REQ-035 SHALL verify: write 0x0000_1010 data 0x1122_3344 strb 3, then read returning 0xFFFF_3344 -> checked pass; a read of untouched 0x0000_1400 -> unchk_count=1.
REQ-036 SHALL verify: accept a read with no response for 64 cycles -> timeout_err=1, busy=0; a response 5 cycles later -> proto_err=1.
REQ-037 SHALL verify: a resp_valid pulse in S_IDLE -> proto_err=1; then rst high 1 cycle -> all outputs 0.
REQ-038 SHALL verify: 64 random writes and reads against a memory that always returns the last written data -> err_count=0, proto_err=0.
